// File: rtl/sync_fifo_v2.sv
// sync_fifo_v2 -- single-clock stream FIFO between LZ77 pipeline stages.
//
// A simple dual-port RAM holds the words and infers block RAM. The output
// word and valid are registered. Reset is synchronous and active-low.
// The fill level and almost-full/almost-empty flags are registered too.
// A synchronous flush empties the FIFO. An optional drop-on-full mode
// keeps i_rdy high and counts discarded words in a saturating counter.
//
// Ports:
//   clk          in   rising-edge clock for all logic
//   rstn         in   synchronous active-low reset
//   flush        in   synchronous clear of FIFO contents
//   i_rdy        out  input ready
//   i_en         in   input valid
//   i_data       in   input word (DW bits)
//   o_rdy        in   consumer ready
//   o_en         out  output valid
//   o_data       out  output word (DW bits)
//   level        out  words accepted and not yet popped (AW+1 bits)
//   almost_full  out  level >= AF_LVL
//   almost_empty out  level <= AE_LVL
//   drop_cnt     out  words discarded while full (DROP_MODE=1), saturating
module sync_fifo_v2 #(
  parameter int DW        = 8,
  parameter int AW        = 12,
  parameter int AF_LVL    = 2**AW-4,
  parameter int AE_LVL    = 4,
  parameter int DROP_MODE = 0
) (
  input  logic          clk,
  input  logic          rstn,
  input  logic          flush,
  output logic          i_rdy,
  input  logic          i_en,
  input  logic [DW-1:0] i_data,
  input  logic          o_rdy,
  output logic          o_en,
  output logic [DW-1:0] o_data,
  output logic [AW:0]   level,
  output logic          almost_full,
  output logic          almost_empty,
  output logic [15:0]   drop_cnt
);

  localparam logic [AW:0] AfLvl = (AW+1)'(AF_LVL);
  localparam logic [AW:0] AeLvl = (AW+1)'(AE_LVL);
  localparam logic [AW:0] FullXor = {1'b1, {AW{1'b0}}};

  logic [AW:0]   wptr_q, wptr_d;
  logic [AW:0]   rptr_q, rptr_d;
  logic [AW:0]   wptrDly1_q, wptrDly1_d;
  logic [AW:0]   wptrDly2_q, wptrDly2_d;
  logic [AW:0]   level_q, level_d;
  logic          oEn_q, oEn_d;
  logic          almostFull_q, almostFull_d;
  logic          almostEmpty_q, almostEmpty_d;
  logic [15:0]   dropCnt_q, dropCnt_d;
  logic [DW-1:0] oData_q;
  logic [DW-1:0] mem [0:(2**AW)-1];

  logic full;
  logic wrEn;
  logic dropEn;
  logic pop;

  // Full is detected when the pointers differ only in their extra wrap bit.
  // Writes and drops are decided from the current full state, so a pop in
  // the same cycle never makes room for a word arriving in that cycle.
  // During a flush, no write and no drop happen at all.
  always_comb begin
    full   = ((wptr_q ^ rptr_q) == FullXor);
    i_rdy  = (DROP_MODE != 0) ? 1'b1 : !full;
    wrEn   = i_en & !full & !flush;
    dropEn = (DROP_MODE != 0) & i_en & full & !flush;
    pop    = oEn_q & o_rdy;
  end

  // Next-state logic. The write pointer passes through two delay stages
  // before the read side compares against it. This gives the RAM write time
  // to settle before the registered read picks the word up, so a word shows
  // on the output three edges after it is accepted. A flush zeroes every
  // pointer but keeps the drop counter. Level and flags are computed from
  // the undelayed pointers after this edge's update.
  always_comb begin
    wptr_d     = wptr_q;
    rptr_d     = rptr_q;
    wptrDly1_d = wptr_q;
    wptrDly2_d = wptrDly1_q;
    oEn_d      = oEn_q;
    dropCnt_d  = dropCnt_q;
    if (flush) begin
      wptr_d     = '0;
      rptr_d     = '0;
      wptrDly1_d = '0;
      wptrDly2_d = '0;
      oEn_d      = 1'b0;
    end else begin
      wptr_d = wptr_q + (AW+1)'(wrEn);
      rptr_d = rptr_q + (AW+1)'(pop);
      oEn_d  = (rptr_d != wptrDly2_q);
      if (dropEn && (dropCnt_q != 16'hFFFF)) begin
        dropCnt_d = dropCnt_q + 16'd1;
      end
    end
    level_d       = wptr_d - rptr_d;
    almostFull_d  = (level_d >= AfLvl);
    almostEmpty_d = (level_d <= AeLvl);
  end

  // Control registers with a synchronous active-low reset. Reset behaves
  // like a flush and also clears the drop counter.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      wptr_q        <= '0;
      rptr_q        <= '0;
      wptrDly1_q    <= '0;
      wptrDly2_q    <= '0;
      level_q       <= '0;
      oEn_q         <= 1'b0;
      almostFull_q  <= (AF_LVL == 0);
      almostEmpty_q <= 1'b1;
      dropCnt_q     <= '0;
    end else begin
      wptr_q        <= wptr_d;
      rptr_q        <= rptr_d;
      wptrDly1_q    <= wptrDly1_d;
      wptrDly2_q    <= wptrDly2_d;
      level_q       <= level_d;
      oEn_q         <= oEn_d;
      almostFull_q  <= almostFull_d;
      almostEmpty_q <= almostEmpty_d;
      dropCnt_q     <= dropCnt_d;
    end
  end

  // RAM with a registered read port and no reset, so it maps onto block RAM.
  // The read address is the next read pointer. While the consumer stalls,
  // the same slot is read again, and that slot cannot be written until it
  // is popped, so o_data holds steady.
  always_ff @(posedge clk) begin
    if (wrEn) begin
      mem[wptr_q[AW-1:0]] <= i_data;
    end
    oData_q <= mem[rptr_d[AW-1:0]];
  end

  assign o_en         = oEn_q;
  assign o_data       = oData_q;
  assign level        = level_q;
  assign almost_full  = almostFull_q;
  assign almost_empty = almostEmpty_q;
  assign drop_cnt     = dropCnt_q;

endmodule

// File: tb/tb_sync_fifo_v2.sv
// Testbench for sync_fifo_v2. Three instances share one set of inputs:
//   u0: AW=4 back-pressure, u1: AW=4 drop-on-full, u2: AW=3 back-pressure.
// A reference model (queue of accepted words tagged with their accept edge)
// predicts valid, level, flags, ready and drop count for the selected one.
module tb_sync_fifo_v2;

  logic       clk = 1'b0;
  logic       rstn, flush, i_en, o_rdy;
  logic [7:0] i_data;

  logic       iRdy0, oEn0, af0, ae0, iRdy1, oEn1, af1, ae1, iRdy2, oEn2, af2, ae2;
  logic [7:0] oData0, oData1, oData2;
  logic [4:0] level0, level1;
  logic [3:0] level2;
  logic [15:0] drop0, drop1, drop2;

  // Free-running clock, period 10.
  always #5 clk = ~clk;

  sync_fifo_v2 #(.DW(8), .AW(4), .AF_LVL(12), .AE_LVL(4), .DROP_MODE(0)) u0 (
    .clk(clk), .rstn(rstn), .flush(flush), .i_rdy(iRdy0), .i_en(i_en),
    .i_data(i_data), .o_rdy(o_rdy), .o_en(oEn0), .o_data(oData0),
    .level(level0), .almost_full(af0), .almost_empty(ae0), .drop_cnt(drop0));

  sync_fifo_v2 #(.DW(8), .AW(4), .AF_LVL(12), .AE_LVL(4), .DROP_MODE(1)) u1 (
    .clk(clk), .rstn(rstn), .flush(flush), .i_rdy(iRdy1), .i_en(i_en),
    .i_data(i_data), .o_rdy(o_rdy), .o_en(oEn1), .o_data(oData1),
    .level(level1), .almost_full(af1), .almost_empty(ae1), .drop_cnt(drop1));

  sync_fifo_v2 #(.DW(8), .AW(3), .AF_LVL(6), .AE_LVL(2), .DROP_MODE(0)) u2 (
    .clk(clk), .rstn(rstn), .flush(flush), .i_rdy(iRdy2), .i_en(i_en),
    .i_data(i_data), .o_rdy(o_rdy), .o_en(oEn2), .o_data(oData2),
    .level(level2), .almost_full(af2), .almost_empty(ae2), .drop_cnt(drop2));

  typedef struct {
    logic [7:0] data;
    int         edgeNo;
  } entry_t;

  entry_t      sb[$];
  int          vectors = 0;
  int          miscompares = 0;
  int          sel = 0;
  int          mDepth = 16, mAf = 12, mAe = 4;
  bit          mDrop = 0;
  logic        mOEn = 1'b0;
  logic [15:0] mDrops = 16'h0;
  int          edgeCnt = 0;

  logic        obsIRdy, obsOEn, obsAF, obsAE;
  logic [7:0]  obsData;
  logic [4:0]  obsLevel;
  logic [15:0] obsDrop;
  logic [24:0] obsVec;

  // Route the outputs of the instance under test onto common observation nets.
  always_comb begin
    obsIRdy = iRdy0; obsOEn = oEn0; obsAF = af0; obsAE = ae0;
    obsData = oData0; obsLevel = level0; obsDrop = drop0;
    case (sel)
      1: begin
        obsIRdy = iRdy1; obsOEn = oEn1; obsAF = af1; obsAE = ae1;
        obsData = oData1; obsLevel = level1; obsDrop = drop1;
      end
      2: begin
        obsIRdy = iRdy2; obsOEn = oEn2; obsAF = af2; obsAE = ae2;
        obsData = oData2; obsLevel = {1'b0, level2}; obsDrop = drop2;
      end
      default: ;
    endcase
    obsVec = {obsOEn, obsLevel, obsAF, obsAE, obsIRdy, obsDrop};
  end

  // Expected {o_en, level, almost_full, almost_empty, i_rdy, drop_cnt}.
  function automatic logic [24:0] expVec();
    logic [4:0] lv;
    lv = 5'(sb.size());
    return {mOEn, lv, (sb.size() >= mAf), (sb.size() <= mAe),
            (mDrop || (sb.size() < mDepth)), mDrops};
  endfunction

  task automatic selectDut(input int s);
    sel    = s;
    mDepth = (s == 2) ? 8 : 16;
    mAf    = (s == 2) ? 6 : 12;
    mAe    = (s == 2) ? 2 : 4;
    mDrop  = (s == 1);
  endtask

  // One clock edge. The model updates from the inputs and its own state
  // before the edge. Control returns 1 time unit after the edge.
  task automatic tick();
    bit acc, pop;
    @(posedge clk);
    if (!rstn) begin
      sb.delete();
      mOEn   = 1'b0;
      mDrops = 16'h0;
    end else if (flush) begin
      sb.delete();
      mOEn = 1'b0;
    end else begin
      acc = i_en && (sb.size() < mDepth);
      pop = mOEn && o_rdy;
      if (pop) void'(sb.pop_front());
      if (acc) sb.push_back('{i_data, edgeCnt});
      else if (i_en && mDrop && mDrops != 16'hFFFF) mDrops = mDrops + 16'd1;
      mOEn = (sb.size() > 0) && (sb[0].edgeNo + 3 <= edgeCnt);
    end
    edgeCnt++;
    #1;
  endtask

  task automatic doReset();
    rstn = 1'b0; flush = 1'b0; i_en = 1'b0; o_rdy = 1'b0; i_data = 8'h0;
    tick();
    rstn = 1'b1;
  endtask

  task automatic test_reset();
    selectDut(0);
    rstn = 1'b0; flush = 1'b0; i_en = 1'b1; o_rdy = 1'b1; i_data = 8'h77;
    tick();
    rstn = 1'b1; i_en = 1'b0; o_rdy = 1'b0;
    vectors++;
    if (obsVec !== {1'b0, 5'd0, 1'b0, 1'b1, 1'b1, 16'h0}) begin
      miscompares++;
      $display("[TB] FAIL reset_state got=%h exp=%h", obsVec, {1'b0, 5'd0, 1'b0, 1'b1, 1'b1, 16'h0});
    end
  endtask

  task automatic test_back_to_back();
    int firstEn;
    selectDut(0);
    doReset();
    firstEn = -1;
    o_rdy = 1'b1;
    for (int k = 0; k < 12; k++) begin
      i_en   = (k < 5);
      i_data = 8'(k + 1);
      tick();
      vectors++;
      if (obsVec !== expVec()) begin
        miscompares++;
        $display("[TB] FAIL b2b_state k=%0d got=%h exp=%h", k, obsVec, expVec());
      end
      if (mOEn) begin
        vectors++;
        if (obsData !== sb[0].data) begin
          miscompares++;
          $display("[TB] FAIL b2b_data k=%0d got=%h exp=%h", k, obsData, sb[0].data);
        end
      end
      if (obsOEn && firstEn < 0) firstEn = k;
    end
    vectors++;
    if (firstEn !== 3) begin
      miscompares++;
      $display("[TB] FAIL b2b_latency got=%0d exp=3", firstEn);
    end
    i_en = 1'b0;
  endtask

  task automatic test_full();
    selectDut(0);
    doReset();
    o_rdy = 1'b0;
    for (int k = 0; k < 20; k++) begin
      i_en = 1'b1; i_data = 8'(8'h40 + k);
      tick();
      vectors++;
      if (obsVec !== expVec()) begin
        miscompares++;
        $display("[TB] FAIL full_state k=%0d got=%h exp=%h", k, obsVec, expVec());
      end
    end
    vectors++;
    if ({obsLevel, obsIRdy, obsAF} !== {5'd16, 1'b0, 1'b1}) begin
      miscompares++;
      $display("[TB] FAIL full_boundary got lvl=%0d rdy=%b af=%b exp lvl=16 rdy=0 af=1", obsLevel, obsIRdy, obsAF);
    end
    o_rdy = 1'b1; i_en = 1'b1; i_data = 8'hEE;
    tick();
    o_rdy = 1'b0; i_en = 1'b0;
    vectors++;
    if ({obsLevel, obsIRdy} !== {5'd15, 1'b1}) begin
      miscompares++;
      $display("[TB] FAIL full_pop got lvl=%0d rdy=%b exp lvl=15 rdy=1", obsLevel, obsIRdy);
    end
    o_rdy = 1'b1;
    for (int k = 0; k < 18; k++) begin
      tick();
      vectors++;
      if (obsVec !== expVec()) begin
        miscompares++;
        $display("[TB] FAIL full_drain k=%0d got=%h exp=%h", k, obsVec, expVec());
      end
      if (mOEn) begin
        vectors++;
        if (obsData !== sb[0].data) begin
          miscompares++;
          $display("[TB] FAIL full_data k=%0d got=%h exp=%h", k, obsData, sb[0].data);
        end
      end
    end
  endtask

  task automatic test_drop();
    selectDut(1);
    doReset();
    o_rdy = 1'b0;
    for (int k = 0; k < 20; k++) begin
      i_en = 1'b1; i_data = 8'(8'h80 + k);
      tick();
      vectors++;
      if (obsVec !== expVec()) begin
        miscompares++;
        $display("[TB] FAIL drop_state k=%0d got=%h exp=%h", k, obsVec, expVec());
      end
    end
    vectors++;
    if ({obsDrop, obsLevel} !== {16'd4, 5'd16}) begin
      miscompares++;
      $display("[TB] FAIL drop_count got cnt=%0d lvl=%0d exp cnt=4 lvl=16", obsDrop, obsLevel);
    end
    i_en = 1'b0; o_rdy = 1'b1;
    for (int k = 0; k < 20; k++) begin
      if (obsOEn) begin
        vectors++;
        if (obsData !== 8'(8'h80 + k)) begin
          miscompares++;
          $display("[TB] FAIL drop_order k=%0d got=%h exp=%h", k, obsData, 8'(8'h80 + k));
        end
      end
      tick();
      vectors++;
      if (obsVec !== expVec()) begin
        miscompares++;
        $display("[TB] FAIL drop_drain k=%0d got=%h exp=%h", k, obsVec, expVec());
      end
    end
  endtask

  task automatic test_flush();
    int firstEn;
    selectDut(0);
    doReset();
    o_rdy = 1'b0;
    for (int k = 0; k < 14; k++) begin
      i_en = (k < 10); i_data = 8'(8'h20 + k);
      tick();
    end
    vectors++;
    if (obsVec !== expVec()) begin
      miscompares++;
      $display("[TB] FAIL flush_pre got=%h exp=%h", obsVec, expVec());
    end
    i_en = 1'b1; o_rdy = 1'b1; flush = 1'b1; i_data = 8'h99;
    tick();
    flush = 1'b0;
    vectors++;
    if ({obsLevel, obsOEn, obsIRdy} !== {5'd0, 1'b0, 1'b1}) begin
      miscompares++;
      $display("[TB] FAIL flush_clear got lvl=%0d en=%b rdy=%b exp lvl=0 en=0 rdy=1", obsLevel, obsOEn, obsIRdy);
    end
    firstEn = -1;
    for (int k = 0; k < 8; k++) begin
      i_en = (k == 0); i_data = 8'hC3;
      tick();
      vectors++;
      if (obsVec !== expVec()) begin
        miscompares++;
        $display("[TB] FAIL flush_after k=%0d got=%h exp=%h", k, obsVec, expVec());
      end
      if (obsOEn && firstEn < 0) begin
        firstEn = k;
        vectors++;
        if (obsData !== 8'hC3) begin
          miscompares++;
          $display("[TB] FAIL flush_word got=%h exp=c3", obsData);
        end
      end
    end
    vectors++;
    if (firstEn !== 3) begin
      miscompares++;
      $display("[TB] FAIL flush_latency got=%0d exp=3", firstEn);
    end
  endtask

  task automatic test_random();
    selectDut(2);
    doReset();
    for (int k = 0; k < 10000; k++) begin
      i_en   = ($urandom_range(0, 2) != 0);
      o_rdy  = ($urandom_range(0, 2) != 0);
      flush  = ($urandom_range(0, 499) == 0);
      i_data = 8'($urandom);
      tick();
      vectors++;
      if (obsVec !== expVec()) begin
        miscompares++;
        $display("[TB] FAIL rand_state k=%0d got=%h exp=%h", k, obsVec, expVec());
      end
      if (mOEn) begin
        vectors++;
        if (obsData !== sb[0].data) begin
          miscompares++;
          $display("[TB] FAIL rand_data k=%0d got=%h exp=%h", k, obsData, sb[0].data);
        end
      end
    end
    flush = 1'b0; i_en = 1'b0;
  endtask

  task automatic test_midreset();
    int reads;
    logic [7:0] lastData;
    selectDut(1);
    doReset();
    o_rdy = 1'b0;
    for (int k = 0; k < 18; k++) begin
      i_en = 1'b1; i_data = 8'(8'h10 + k);
      tick();
    end
    i_en = 1'b0; o_rdy = 1'b1;
    for (int k = 0; k < 10; k++) tick();
    vectors++;
    if ({obsLevel, obsDrop} !== {5'd6, 16'd2} || obsVec !== expVec()) begin
      miscompares++;
      $display("[TB] FAIL midrst_pre got=%h exp lvl=6 cnt=2 model=%h", obsVec, expVec());
    end
    rstn = 1'b0; i_en = 1'b1; i_data = 8'hEE;
    tick();
    rstn = 1'b1; i_en = 1'b0;
    vectors++;
    if (obsVec !== {1'b0, 5'd0, 1'b0, 1'b1, 1'b1, 16'h0}) begin
      miscompares++;
      $display("[TB] FAIL midrst_state got=%h exp=%h", obsVec, {1'b0, 5'd0, 1'b0, 1'b1, 1'b1, 16'h0});
    end
    i_en = 1'b1; i_data = 8'h5A;
    tick();
    i_en = 1'b0;
    reads = 0; lastData = 8'h00;
    for (int k = 0; k < 8; k++) begin
      tick();
      if (obsOEn) begin
        reads++;
        lastData = obsData;
      end
    end
    vectors++;
    if (reads !== 1 || lastData !== 8'h5A) begin
      miscompares++;
      $display("[TB] FAIL midrst_read got reads=%0d data=%h exp reads=1 data=5a", reads, lastData);
    end
  endtask

  // Run every scenario in sequence, then report.
  initial begin
    rstn = 1'b0; flush = 1'b0; i_en = 1'b0; o_rdy = 1'b0; i_data = 8'h0;
    test_reset();
    test_back_to_back();
    test_full();
    test_drop();
    test_flush();
    test_random();
    test_midreset();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
